// File: rtl/operand_fetch_ctrl_pkg.sv
// Shared types for the operand fetch controller: addressing modes, FSM
// states, the captured fetch request and the byte-lane helper.
package operand_fetch_ctrl_pkg;

  localparam logic [2:0]  IDX_REG      = 3'd7;   // index word comes from R7
  localparam logic [2:0]  FIRST_WORD_REG = 3'd6; // R6/R7 always step by a word
  localparam logic [15:0] STEP_BYTE    = 16'd1;
  localparam logic [15:0] STEP_WORD    = 16'd2;

  typedef enum logic [2:0] {
    AM_REG         = 3'd0,
    AM_IND         = 3'd1,
    AM_POSTINC     = 3'd2,
    AM_PTR_POSTINC = 3'd3,
    AM_PREDEC      = 3'd4,
    AM_PTR_PREDEC  = 3'd5,
    AM_INDEX       = 3'd6,
    AM_INDEX_PTR   = 3'd7
  } addr_mode_t;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CALC    = 3'd1,
    S_IDX     = 3'd2,
    S_IDX_ADD = 3'd3,
    S_PTR     = 3'd4,
    S_OPND    = 3'd5,
    S_DONE    = 3'd6
  } ofc_state_t;

  typedef struct packed {
    addr_mode_t mode;
    logic [2:0] regsel;
    logic       byte_op;
  } fetch_req_t;

  // Byte accesses take the high lane at odd addresses, zero-extended.
  function automatic logic [15:0] pick_operand(input logic [15:0] rdata,
                                               input logic        byte_op,
                                               input logic        odd_addr);
    if (!byte_op)     return rdata;
    else if (odd_addr) return {8'h00, rdata[15:8]};
    else               return {8'h00, rdata[7:0]};
  endfunction

endpackage

// File: rtl/operand_fetch_ctrl_step_calc.sv
// Purely combinational step size and odd-address detection.
module ofc_step_calc
  import operand_fetch_ctrl_pkg::*;
(
  input  logic        byte_op_i,
  input  logic [2:0]  regsel_i,
  input  logic        word_access_i,
  input  logic [15:0] addr_i,
  output logic [15:0] step_o,
  output logic        odd_o
);

  // Only R0..R5 step by a byte; R6/R7 stay word aligned.
  assign step_o = (byte_op_i && (regsel_i < FIRST_WORD_REG)) ? STEP_BYTE : STEP_WORD;
  // A word access to an odd address must not reach memory.
  assign odd_o  = word_access_i && addr_i[0];

endmodule

// File: rtl/operand_fetch_ctrl.sv
// Operand fetch controller: resolves the addressing mode, performs the
// register updates and memory reads, and returns the operand.
//
// Memory handshake: mem_req is high with a stable mem_addr until the cycle in
// which mem_ack is seen high together with mem_req; that cycle completes the
// transfer. mem_ack while mem_req is low is ignored.
module operand_fetch_ctrl
  import operand_fetch_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  mode,
  input  logic [2:0]  regsel,
  input  logic        byte_op,
  output logic [2:0]  rf_rd_addr,
  input  logic [15:0] rf_rd_data,
  output logic        rf_wr_en,
  output logic [2:0]  rf_wr_addr,
  output logic [15:0] rf_wr_data,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        busy,
  output logic        done,
  output logic [15:0] operand,
  output logic [15:0] ea,
  output logic        ea_valid,
  output logic        odd_err,
  output ofc_state_t  dbg_state
);

  ofc_state_t  state_q;
  fetch_req_t  req_q;
  logic [15:0] ea_q, ptr_q, x_q, operand_q;
  logic        ea_valid_q, odd_err_q;

  logic [15:0] step, idx_sum, mem_addr_c;
  logic        word_acc, in_access, odd, mem_hs;

  ofc_step_calc u_step (
    .byte_op_i     (req_q.byte_op),
    .regsel_i      (req_q.regsel),
    .word_access_i (word_acc),
    .addr_i        (mem_addr_c),
    .step_o        (step),
    .odd_o         (odd)
  );

  // IDX reads R7 for the index address; every other state reads R[regsel].
  assign rf_rd_addr = (state_q == S_IDX) ? IDX_REG : req_q.regsel;
  assign idx_sum    = rf_rd_data + x_q;

  // Address source and access width for the state's memory access.
  // IDX_ADD folds the index add into the following access so the indexed
  // path does not spend a separate cycle on the addition.
  always_comb begin
    mem_addr_c = 16'h0000;
    word_acc   = 1'b1;
    in_access  = 1'b0;
    case (state_q)
      S_IDX: begin
        mem_addr_c = rf_rd_data;
        in_access  = 1'b1;
      end
      S_IDX_ADD: begin
        mem_addr_c = idx_sum;
        in_access  = 1'b1;
        word_acc   = (req_q.mode == AM_INDEX_PTR) || !req_q.byte_op;
      end
      S_PTR: begin
        mem_addr_c = ptr_q;
        in_access  = 1'b1;
      end
      S_OPND: begin
        mem_addr_c = ea_q;
        in_access  = 1'b1;
        word_acc   = !req_q.byte_op;
      end
      default: ;
    endcase
  end

  assign mem_req  = in_access && !odd;
  assign mem_addr = mem_addr_c;
  assign mem_hs   = mem_req && mem_ack;

  // Register-file write-back: one update in CALC, or R7 on the index fetch.
  always_comb begin
    rf_wr_en   = 1'b0;
    rf_wr_addr = req_q.regsel;
    rf_wr_data = 16'h0000;
    case (state_q)
      S_CALC: begin
        case (req_q.mode)
          AM_POSTINC:     begin rf_wr_en = 1'b1; rf_wr_data = rf_rd_data + step;      end
          AM_PTR_POSTINC: begin rf_wr_en = 1'b1; rf_wr_data = rf_rd_data + STEP_WORD; end
          AM_PREDEC:      begin rf_wr_en = 1'b1; rf_wr_data = rf_rd_data - step;      end
          AM_PTR_PREDEC:  begin rf_wr_en = 1'b1; rf_wr_data = rf_rd_data - STEP_WORD; end
          default: ;
        endcase
      end
      S_IDX: begin
        if (mem_hs) begin
          rf_wr_en   = 1'b1;
          rf_wr_addr = IDX_REG;
          rf_wr_data = rf_rd_data + STEP_WORD;
        end
      end
      default: ;
    endcase
  end

  // Fetch sequencer with registered result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      req_q      <= '0;
      ea_q       <= '0;
      ptr_q      <= '0;
      x_q        <= '0;
      operand_q  <= '0;
      ea_valid_q <= 1'b0;
      odd_err_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            req_q      <= '{mode: addr_mode_t'(mode), regsel: regsel, byte_op: byte_op};
            operand_q  <= '0;
            ea_q       <= '0;
            ea_valid_q <= 1'b0;
            odd_err_q  <= 1'b0;
            state_q    <= S_CALC;
          end
        end
        S_CALC: begin
          case (req_q.mode)
            AM_REG:         begin operand_q <= rf_rd_data; state_q <= S_DONE; end
            AM_IND,
            AM_POSTINC:     begin ea_q <= rf_rd_data; ea_valid_q <= 1'b1; state_q <= S_OPND; end
            AM_PTR_POSTINC: begin ptr_q <= rf_rd_data; state_q <= S_PTR; end
            AM_PREDEC:      begin ea_q <= rf_rd_data - step; ea_valid_q <= 1'b1; state_q <= S_OPND; end
            AM_PTR_PREDEC:  begin ptr_q <= rf_rd_data - STEP_WORD; state_q <= S_PTR; end
            default:        state_q <= S_IDX;
          endcase
        end
        S_IDX: begin
          if (odd) begin
            odd_err_q <= 1'b1;
            state_q   <= S_DONE;
          end else if (mem_hs) begin
            x_q     <= mem_rdata;
            state_q <= S_IDX_ADD;
          end
        end
        S_IDX_ADD: begin
          if (req_q.mode == AM_INDEX) begin
            ea_q       <= idx_sum;
            ea_valid_q <= 1'b1;
          end
          if (odd) begin
            odd_err_q <= 1'b1;
            state_q   <= S_DONE;
          end else if (mem_hs) begin
            if (req_q.mode == AM_INDEX) begin
              operand_q <= pick_operand(mem_rdata, req_q.byte_op, idx_sum[0]);
              state_q   <= S_DONE;
            end else begin
              ea_q       <= mem_rdata;
              ea_valid_q <= 1'b1;
              state_q    <= S_OPND;
            end
          end
        end
        S_PTR: begin
          if (odd) begin
            odd_err_q <= 1'b1;
            state_q   <= S_DONE;
          end else if (mem_hs) begin
            ea_q       <= mem_rdata;
            ea_valid_q <= 1'b1;
            state_q    <= S_OPND;
          end
        end
        S_OPND: begin
          if (odd) begin
            odd_err_q <= 1'b1;
            state_q   <= S_DONE;
          end else if (mem_hs) begin
            operand_q <= pick_operand(mem_rdata, req_q.byte_op, ea_q[0]);
            state_q   <= S_DONE;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign operand   = operand_q;
  assign ea        = ea_q;
  assign ea_valid  = ea_valid_q;
  assign odd_err   = odd_err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_operand_fetch_ctrl.sv
// Self-checking bench for operand_fetch_ctrl: register file and memory
// models around the DUT, a behavioural fetch model, directed and random runs.
module tb_operand_fetch_ctrl;
  import operand_fetch_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        start, byte_op;
  logic [2:0]  mode, regsel, rf_rd_addr, rf_wr_addr;
  logic [15:0] rf_rd_data, rf_wr_data, mem_addr, mem_rdata, operand, ea;
  logic        rf_wr_en, mem_req, mem_ack, busy, done, ea_valid, odd_err;
  ofc_state_t  dbg_state;

  operand_fetch_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .regsel(regsel),
    .byte_op(byte_op), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .busy(busy), .done(done), .operand(operand),
    .ea(ea), .ea_valid(ea_valid), .odd_err(odd_err), .dbg_state(dbg_state)
  );

  // ---------------- environment: register file ----------------
  logic [15:0] rf [0:7];
  logic        pre_we = 1'b0;
  logic [2:0]  pre_addr = 3'd0;
  logic [15:0] pre_data = 16'h0;
  assign rf_rd_data = rf[rf_rd_addr];
  always @(posedge clk) begin
    if (pre_we)        rf[pre_addr]   <= pre_data;
    else if (rf_wr_en) rf[rf_wr_addr] <= rf_wr_data;
  end

  // ---------------- environment: memory with wait states ----------------
  logic [15:0] mem_w [0:32767];
  int          mem_lat = 0;
  int          wcnt = 0;
  logic        junk_ack = 1'b0;
  assign mem_rdata = mem_w[mem_addr[15:1]];
  assign mem_ack   = mem_req ? (wcnt == mem_lat) : junk_ack;
  always @(posedge clk) begin
    junk_ack <= 1'($urandom_range(0, 1));
    if (!mem_req || mem_ack) wcnt <= 0;
    else                     wcnt <= wcnt + 1;
  end

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_q[$];
  logic [15:0] m_rf [0:7];
  logic [15:0] e_operand, e_ea;
  bit          e_ea_valid, e_odd;
  int          e_nacc, e_nwr, e_lat;
  int          lat_tab [0:7] = '{2, 3, 3, 4, 3, 4, 4, 5};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic mem_read(input logic [15:0] a, output logic [15:0] d);
    exp_q.push_back(a);
    e_nacc++;
    d = mem_w[a[15:1]];
  endtask

  // Walks one fetch through the addressing rules, updating m_rf and
  // queueing the expected memory addresses.
  task automatic model_fetch(input int md, input int rs, input bit bop);
    logic [15:0] r, inc, ptr, addr, x, w;
    inc = (bop && rs < 6) ? 16'd1 : 16'd2;
    e_operand = 16'h0; e_ea = 16'h0; e_ea_valid = 0; e_odd = 0;
    e_nacc = 0; e_nwr = 0; e_lat = lat_tab[md];
    ptr = 16'h0; addr = 16'h0;
    r = m_rf[rs];
    case (md)
      0: begin e_operand = r; return; end
      1: addr = r;
      2: begin addr = r; m_rf[rs] = r + inc; e_nwr++; end
      3: begin ptr = r; m_rf[rs] = r + 16'd2; e_nwr++; end
      4: begin addr = r - inc; m_rf[rs] = addr; e_nwr++; end
      5: begin ptr = r - 16'd2; m_rf[rs] = ptr; e_nwr++; end
      default: begin
        if (m_rf[7][0]) begin e_odd = 1; return; end
        mem_read(m_rf[7], x);
        m_rf[7] = m_rf[7] + 16'd2; e_nwr++;
        if (md == 6) addr = m_rf[rs] + x;
        else         ptr  = m_rf[rs] + x;
      end
    endcase
    if (md == 3 || md == 5 || md == 7) begin
      if (ptr[0]) begin e_odd = 1; return; end
      mem_read(ptr, addr);
    end
    e_ea = addr; e_ea_valid = 1;
    if (!bop && addr[0]) begin e_odd = 1; return; end
    mem_read(addr, w);
    if (!bop)         e_operand = w;
    else if (addr[0]) e_operand = {8'h00, w[15:8]};
    else              e_operand = {8'h00, w[7:0]};
  endtask

  // ---------------- driver tasks ----------------
  task automatic load_rf();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      pre_we = 1'b1; pre_addr = 3'(i); pre_data = m_rf[i];
    end
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic check_rf(input string tag);
    for (int i = 0; i < 8; i++) check_eq(tag, rf[i], m_rf[i]);
  endtask

  task automatic run_fetch(input int md, input int rs, input bit bop, input int lat);
    int cyc, nhs, nwr, done_cyc;
    bit seen, prev_wait;
    logic [15:0] prev_addr;
    load_rf();
    mem_lat = lat;
    exp_q.delete();
    model_fetch(md, rs, bop);
    @(negedge clk);
    mode = 3'(md); regsel = 3'(rs); byte_op = bop; start = 1'b1;
    cyc = 0; nhs = 0; nwr = 0; done_cyc = 0; seen = 0; prev_wait = 0; prev_addr = 16'h0;
    while (!seen && cyc < 60) begin
      @(negedge clk);
      cyc++;
      // inputs churn while busy; they must not disturb the fetch
      start = 1'($urandom_range(0, 1)); mode = 3'($urandom);
      regsel = 3'($urandom); byte_op = 1'($urandom);
      if (prev_wait && mem_req) check_eq("addr_stable", mem_addr, prev_addr);
      if (rf_wr_en) nwr++;
      if (mem_req && mem_ack) begin
        nhs++;
        if (exp_q.size() > 0) check_eq("mem_addr", mem_addr, exp_q.pop_front());
      end
      prev_wait = mem_req && !mem_ack;
      prev_addr = mem_addr;
      if (done) begin seen = 1; done_cyc = cyc; end
    end
    check_eq("done_seen", 32'(seen), 32'd1);
    check_eq("operand", operand, e_operand);
    check_eq("ea_valid", ea_valid, e_ea_valid);
    if (e_ea_valid) check_eq("ea", ea, e_ea);
    check_eq("odd_err", odd_err, e_odd);
    check_eq("busy_in_done", busy, 1'b1);
    if (!e_odd) check_eq("latency", done_cyc, e_lat + lat * e_nacc);
    @(negedge clk);
    start = 1'b0;
    check_eq("done_one_cycle", done, 1'b0);
    check_eq("busy_after", busy, 1'b0);
    check_eq("operand_hold", operand, e_operand);
    check_eq("odd_err_hold", odd_err, e_odd);
    check_eq("req_count", nhs, e_nacc);
    check_eq("wr_count", nwr, e_nwr);
    check_eq("exp_q_empty", exp_q.size(), 0);
    check_rf("rf");
    if (!seen) begin
      rst = 1'b1; @(negedge clk); rst = 1'b0;
    end
  endtask

  task automatic rand_rf();
    for (int i = 0; i < 8; i++) begin
      m_rf[i] = 16'($urandom);
      if ($urandom_range(0, 7) != 0) m_rf[i][0] = 1'b0;
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1, "timeout");
  end

  // ---------------- main sequence ----------------
  initial begin
    start = 1'b0; mode = 3'd0; regsel = 3'd0; byte_op = 1'b0;
    for (int i = 0; i < 32768; i++) begin
      mem_w[i] = 16'($urandom);
      if ($urandom_range(0, 7) != 0) mem_w[i][0] = 1'b0;
    end
    rst = 1'b0;
    #1 rst = 1'b1;
    @(negedge clk);
    check_eq("rst_mem_req", mem_req, 1'b0);
    check_eq("rst_wr_en", rf_wr_en, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_operand", operand, 16'h0);
    check_eq("rst_ea", ea, 16'h0);
    check_eq("rst_ea_valid", ea_valid, 1'b0);
    check_eq("rst_odd_err", odd_err, 1'b0);
    check_eq("rst_state", dbg_state, S_IDLE);
    rst = 1'b0;

    // register mode
    rand_rf(); m_rf[3] = 16'h1234;
    run_fetch(0, 3, 1'b0, 0);
    check_eq("m0_operand", operand, 16'h1234);

    // post-increment byte, odd lane, then R6 steps by a word
    rand_rf(); m_rf[1] = 16'h1001; mem_w[16'h1000 >> 1] = 16'hAB55;
    run_fetch(2, 1, 1'b1, 0);
    check_eq("m2_operand", operand, 16'h00AB);
    check_eq("m2_r1", rf[1], 16'h1002);
    m_rf[6] = 16'h1000;
    run_fetch(2, 6, 1'b1, 0);
    check_eq("m2_r6", rf[6], 16'h1002);

    // pre-decrement wraps below zero
    rand_rf(); m_rf[0] = 16'h0000;
    run_fetch(4, 0, 1'b0, 0);
    check_eq("m4_r0", rf[0], 16'hFFFE);

    // indexed pointer
    rand_rf(); m_rf[7] = 16'h0200; m_rf[2] = 16'h0100;
    mem_w[16'h0200 >> 1] = 16'h0010; mem_w[16'h0110 >> 1] = 16'h3000;
    mem_w[16'h3000 >> 1] = 16'hBEEF;
    run_fetch(7, 2, 1'b0, 0);
    check_eq("m7_operand", operand, 16'hBEEF);
    check_eq("m7_r7", rf[7], 16'h0202);

    // odd word address
    rand_rf(); m_rf[4] = 16'h0101;
    run_fetch(1, 4, 1'b0, 0);
    check_eq("m1_odd", odd_err, 1'b1);

    // reset while the pointer fetch waits on memory
    rand_rf(); m_rf[3] = 16'h0400;
    load_rf();
    mem_lat = 3;
    @(negedge clk);
    mode = 3'd3; regsel = 3'd3; byte_op = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check_eq("rst_mid_req_before", mem_req, 1'b1);
    rst = 1'b1;
    #1;
    check_eq("rst_mid_req", mem_req, 1'b0);
    check_eq("rst_mid_busy", busy, 1'b0);
    check_eq("rst_mid_state", dbg_state, S_IDLE);
    check_eq("rst_mid_wr_en", rf_wr_en, 1'b0);
    m_rf[3] = 16'h0402;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_rf("rst_mid_rf");

    // random fetches with random wait states
    for (int t = 0; t < 40; t++) begin
      rand_rf();
      run_fetch($urandom_range(0, 7), $urandom_range(0, 7),
                1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
